// File: rtl/vp_pkg.sv
`default_nettype none
// vp_pkg -- shared widths, entry/slot types and FSM encodings for the V-P decoder.
// Rev 1.0
package vp_pkg;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 16;
  localparam int N_ENT  = 3;

  typedef logic [3*ADDR_W-1:0] vp_addr_t;

  typedef struct packed {
    vp_addr_t                  addr;
    logic signed [DATA_W-1:0]  w;
    logic signed [DATA_W-1:0]  ia;
  } vp_entry_t;

  typedef struct packed {
    vp_entry_t [N_ENT-1:0] ent;
    logic                  full;
  } vp_slot_t;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } vp_state_e;

  typedef enum logic [0:0] {
    SIDE_LEFT  = 1'b0,
    SIDE_RIGHT = 1'b1
  } vp_side_e;

endpackage
`default_nettype wire

// File: rtl/vp_slot_capture.sv
`default_nettype none
// vp_slot_capture -- one ping-pong side: ready edge detect, slot storage, full flag, overrun.
// Rev 1.0
module vp_slot_capture #(
  parameter int ADDR_W = vp_pkg::ADDR_W,
  parameter int DATA_W = vp_pkg::DATA_W,
  parameter int N_ENT  = vp_pkg::N_ENT
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            ready_i,
  input  logic                            release_i,
  input  logic [N_ENT-1:0][3*ADDR_W-1:0]  addr_i,
  input  logic [N_ENT-1:0][DATA_W-1:0]    w_i,
  input  logic [N_ENT-1:0][DATA_W-1:0]    ia_i,
  output logic                            full_o,
  output logic                            capture_o,
  output logic                            overrun_o,
  output logic [N_ENT-1:0][3*ADDR_W-1:0]  addr_o,
  output logic [N_ENT-1:0][DATA_W-1:0]    w_o,
  output logic [N_ENT-1:0][DATA_W-1:0]    ia_o
);
  import vp_pkg::*;

  logic                           armed_q;
  logic                           prev_q;
  logic                           full_q;
  logic                           ovr_q;
  logic [N_ENT-1:0][3*ADDR_W-1:0] addr_q;
  logic [N_ENT-1:0][DATA_W-1:0]   w_q;
  logic [N_ENT-1:0][DATA_W-1:0]   ia_q;
  logic                           rise;
  logic                           accept;

  // armed_q keeps a ready level held across reset from looking like a fresh rise.
  assign rise   = armed_q & ready_i & ~prev_q;
  assign accept = rise & (~full_q | release_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      armed_q <= 1'b0;
      prev_q  <= 1'b0;
      full_q  <= 1'b0;
      ovr_q   <= 1'b0;
      addr_q  <= '0;
      w_q     <= '0;
      ia_q    <= '0;
    end else begin
      armed_q <= 1'b1;
      prev_q  <= ready_i;
      if (accept) begin
        full_q <= 1'b1;
        addr_q <= addr_i;
        w_q    <= w_i;
        ia_q   <= ia_i;
      end else if (release_i) begin
        full_q <= 1'b0;
      end
      if (rise && full_q && !release_i) begin
        ovr_q <= 1'b1;
      end
    end
  end

  assign full_o    = full_q;
  assign capture_o = accept;
  assign overrun_o = ovr_q;
  assign addr_o    = addr_q;
  assign w_o       = w_q;
  assign ia_o      = ia_q;

endmodule
`default_nettype wire

// File: rtl/vp_decoder.sv
`default_nettype none
// vp_decoder -- drains captured V-P ping-pong slots as (address, w*ia) pairs over valid/ready.
// Rev 1.0
module vp_decoder #(
  parameter  int ADDR_W = vp_pkg::ADDR_W,
  parameter  int DATA_W = vp_pkg::DATA_W,
  parameter  int N_ENT  = vp_pkg::N_ENT,
  localparam int PROD_W = 2*DATA_W
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic                            i_left_ready,
  input  logic                            i_right_ready,
  input  logic [N_ENT-1:0][3*ADDR_W-1:0]  i_addr_left_buffer,
  input  logic [N_ENT-1:0][DATA_W-1:0]    i_w_data_left_buffer,
  input  logic [N_ENT-1:0][DATA_W-1:0]    i_ia_data_left_buffer,
  input  logic [N_ENT-1:0][3*ADDR_W-1:0]  i_addr_right_buffer,
  input  logic [N_ENT-1:0][DATA_W-1:0]    i_w_data_right_buffer,
  input  logic [N_ENT-1:0][DATA_W-1:0]    i_ia_data_right_buffer,
  output logic                            o_valid,
  input  logic                            i_ready,
  output logic [3*ADDR_W-1:0]             o_addr,
  output logic signed [PROD_W-1:0]        o_product,
  output logic                            o_busy,
  output logic                            o_overrun
);
  import vp_pkg::*;

  localparam int IDX_W = $clog2(N_ENT) + 1;
  localparam int SEL_W = (N_ENT > 1) ? $clog2(N_ENT) : 1;

  logic                           l_full, r_full, l_cap, r_cap, l_ovr, r_ovr, l_rel, r_rel;
  logic [N_ENT-1:0][3*ADDR_W-1:0] l_addr, r_addr, act_addr;
  logic [N_ENT-1:0][DATA_W-1:0]   l_w, r_w, l_ia, r_ia, act_w, act_ia;

  vp_state_e                      state_q;
  vp_side_e                       cur_q, oldest_q, act_side, other_side;
  logic [IDX_W-1:0]               idx_q, act_idx, next_idx;
  logic [SEL_W-1:0]               sel;
  logic                           act_go, found, more, can_issue, issue, done, other_full;
  logic                           valid_q;
  logic [3*ADDR_W-1:0]            addr_q;
  logic signed [PROD_W-1:0]       prod_q, prod_d;
  logic signed [DATA_W-1:0]       w_sel, ia_sel;

  vp_slot_capture #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .N_ENT(N_ENT)) u_left (
    .clk_i     (i_clk),
    .rst_ni    (i_rst_n),
    .ready_i   (i_left_ready),
    .release_i (l_rel),
    .addr_i    (i_addr_left_buffer),
    .w_i       (i_w_data_left_buffer),
    .ia_i      (i_ia_data_left_buffer),
    .full_o    (l_full),
    .capture_o (l_cap),
    .overrun_o (l_ovr),
    .addr_o    (l_addr),
    .w_o       (l_w),
    .ia_o      (l_ia)
  );

  vp_slot_capture #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .N_ENT(N_ENT)) u_right (
    .clk_i     (i_clk),
    .rst_ni    (i_rst_n),
    .ready_i   (i_right_ready),
    .release_i (r_rel),
    .addr_i    (i_addr_right_buffer),
    .w_i       (i_w_data_right_buffer),
    .ia_i      (i_ia_data_right_buffer),
    .full_o    (r_full),
    .capture_o (r_cap),
    .overrun_o (r_ovr),
    .addr_o    (r_addr),
    .w_o       (r_w),
    .ia_o      (r_ia)
  );

  // From IDLE the oldest full slot is picked and issued in the same cycle, so output follows capture by one edge.
  always_comb begin
    act_go   = 1'b0;
    act_side = cur_q;
    act_idx  = idx_q;
    if (state_q == ST_DRAIN) begin
      act_go = 1'b1;
    end else if (l_full || r_full) begin
      act_go   = 1'b1;
      act_idx  = '0;
      act_side = (l_full && r_full) ? oldest_q : (r_full ? SIDE_RIGHT : SIDE_LEFT);
    end
  end

  assign other_side = (act_side == SIDE_LEFT) ? SIDE_RIGHT : SIDE_LEFT;
  assign other_full = (act_side == SIDE_LEFT) ? r_full : l_full;
  assign act_addr   = (act_side == SIDE_RIGHT) ? r_addr : l_addr;
  assign act_w      = (act_side == SIDE_RIGHT) ? r_w    : l_w;
  assign act_ia     = (act_side == SIDE_RIGHT) ? r_ia   : l_ia;

  // Padding entries (ia == 0) are skipped in the scan, so they cost no cycles.
  always_comb begin
    found = 1'b0;
    more  = 1'b0;
    sel   = '0;
    for (int j = 0; j < N_ENT; j++) begin
      if (act_go && (IDX_W'(j) >= act_idx) && (act_ia[j] != '0)) begin
        if (found) begin
          more = 1'b1;
        end else begin
          found = 1'b1;
          sel   = SEL_W'(j);
        end
      end
    end
  end

  assign w_sel     = act_w[sel];
  assign ia_sel    = act_ia[sel];
  assign prod_d    = PROD_W'(w_sel) * PROD_W'(ia_sel);
  assign next_idx  = IDX_W'(sel) + IDX_W'(1);
  assign can_issue = ~valid_q | i_ready;
  assign issue     = found & can_issue;
  // Releasing on the last issue (not the last transfer) lets the next slot follow without a bubble.
  assign done      = act_go & (~found | (issue & ~more));
  assign l_rel     = done & (act_side == SIDE_LEFT);
  assign r_rel     = done & (act_side == SIDE_RIGHT);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      cur_q    <= SIDE_LEFT;
      oldest_q <= SIDE_LEFT;
      idx_q    <= '0;
      valid_q  <= 1'b0;
      addr_q   <= '0;
      prod_q   <= '0;
    end else begin
      if (valid_q && i_ready) begin
        valid_q <= 1'b0;
      end
      if (issue) begin
        valid_q <= 1'b1;
        addr_q  <= act_addr[sel];
        prod_q  <= prod_d;
      end

      if (done) begin
        idx_q <= '0;
        if (other_full) begin
          state_q <= ST_DRAIN;
          cur_q   <= other_side;
        end else begin
          state_q <= ST_IDLE;
        end
      end else if (act_go) begin
        state_q <= ST_DRAIN;
        cur_q   <= act_side;
        idx_q   <= issue ? next_idx : act_idx;
      end

      // A capture is oldest unless the other side still holds undrained data.
      if (l_cap) begin
        oldest_q <= (r_full && !r_rel) ? SIDE_RIGHT : SIDE_LEFT;
      end else if (r_cap) begin
        oldest_q <= (l_full && !l_rel) ? SIDE_LEFT : SIDE_RIGHT;
      end
    end
  end

  assign o_valid   = valid_q;
  assign o_addr    = addr_q;
  assign o_product = prod_q;
  assign o_busy    = l_full | r_full | valid_q;
  assign o_overrun = l_ovr | r_ovr;

endmodule
`default_nettype wire

// File: tb/tb_vp_decoder.sv
`default_nettype none
// tb_vp_decoder -- directed and randomized checks of vp_decoder against a queue-based pair model.
module tb_vp_decoder;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 16;
  localparam int N_ENT  = 3;
  localparam int PROD_W = 2*DATA_W;

  logic i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  logic                           i_rst_n, i_left_ready, i_right_ready, i_ready;
  logic [N_ENT-1:0][3*ADDR_W-1:0] addr_l, addr_r;
  logic [N_ENT-1:0][DATA_W-1:0]   w_l, w_r, ia_l, ia_r;
  logic                           o_valid, o_busy, o_overrun;
  logic [3*ADDR_W-1:0]            o_addr;
  logic signed [PROD_W-1:0]       o_product;

  int n_assert = 0;
  int n_fail   = 0;
  int n_xfer   = 0;

  logic [3*ADDR_W-1:0] exp_addr[$];
  logic [31:0]         exp_prod[$];

  vp_decoder dut (
    .i_clk                  (i_clk),
    .i_rst_n                (i_rst_n),
    .i_left_ready           (i_left_ready),
    .i_right_ready          (i_right_ready),
    .i_addr_left_buffer     (addr_l),
    .i_w_data_left_buffer   (w_l),
    .i_ia_data_left_buffer  (ia_l),
    .i_addr_right_buffer    (addr_r),
    .i_w_data_right_buffer  (w_r),
    .i_ia_data_right_buffer (ia_r),
    .o_valid                (o_valid),
    .i_ready                (i_ready),
    .o_addr                 (o_addr),
    .o_product              (o_product),
    .o_busy                 (o_busy),
    .o_overrun              (o_overrun)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_entry(input bit right, input int e, input int x, input int y, input int k,
                           input int w, input int ia);
    logic [3*ADDR_W-1:0] a;
    a = {7'(x), 7'(y), 7'(k)};
    if (right) begin
      addr_r[e] = a; w_r[e] = 16'(w); ia_r[e] = 16'(ia);
    end else begin
      addr_l[e] = a; w_l[e] = 16'(w); ia_l[e] = 16'(ia);
    end
  endtask

  task automatic set_random(input bit right, input bit allow_zero);
    for (int e = 0; e < N_ENT; e++) begin
      int ia;
      ia = (allow_zero && ($urandom_range(0, 2) == 0)) ? 0 : int'($urandom_range(1, 65535));
      set_entry(right, e, int'($urandom_range(0, 127)), int'($urandom_range(0, 127)),
                int'($urandom_range(0, 127)), int'($urandom_range(0, 65535)), ia);
    end
  endtask

  // Model: a captured buffer yields its nonzero-activation entries in index order, product w*ia.
  task automatic push_exp(input bit right);
    for (int e = 0; e < N_ENT; e++) begin
      logic [15:0] wv, iv;
      int p;
      wv = right ? w_r[e] : w_l[e];
      iv = right ? ia_r[e] : ia_l[e];
      if (iv != 16'd0) begin
        p = int'($signed(wv)) * int'($signed(iv));
        exp_addr.push_back(right ? addr_r[e] : addr_l[e]);
        exp_prod.push_back(32'(p));
      end
    end
  endtask

  task automatic step();
    logic                hold;
    logic [3*ADDR_W-1:0] ha;
    logic [31:0]         hp;
    hold = o_valid && !i_ready;
    ha   = o_addr;
    hp   = o_product;
    if (o_valid && i_ready) begin
      n_xfer++;
      if (exp_addr.size() == 0) begin
        chk("unexpected_pair", 32'(o_valid), 32'd0);
      end else begin
        chk("pair_addr", 32'(o_addr), 32'(exp_addr.pop_front()));
        chk("pair_prod", o_product, exp_prod.pop_front());
      end
    end
    @(posedge i_clk);
    #1;
    if (hold) begin
      chk("hold_valid", 32'(o_valid), 32'd1);
      chk("hold_addr", 32'(o_addr), 32'(ha));
      chk("hold_prod", o_product, hp);
    end
  endtask

  task automatic drain(input int budget, input bit rnd_ready);
    int k;
    k = 0;
    while ((exp_addr.size() != 0 || o_valid) && k < budget) begin
      if (rnd_ready) i_ready = ($urandom_range(0, 3) != 0);
      step();
      k++;
    end
    chk("drain_remaining", 32'(exp_addr.size()), 32'd0);
    chk("drain_valid", 32'(o_valid), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    i_rst_n = 1'b0; i_left_ready = 1'b0; i_right_ready = 1'b0; i_ready = 1'b0;
    addr_l = '0; addr_r = '0; w_l = '0; w_r = '0; ia_l = '0; ia_r = '0;
    @(posedge i_clk); #1;
    @(posedge i_clk); #1;
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_addr", 32'(o_addr), 32'd0);
    chk("rst_prod", o_product, 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_overrun", 32'(o_overrun), 32'd0);
    i_rst_n = 1'b1;
    step(); step();

    // Single left buffer, i_ready high throughout.
    set_entry(0, 0, 1, 2, 3, 5, 2);
    set_entry(0, 1, 4, 5, 6, -6, 3);
    set_entry(0, 2, 7, 8, 9, 7, 4);
    push_exp(0);
    i_ready = 1'b1; i_left_ready = 1'b1;
    step();
    chk("t1_latency_T0", 32'(o_valid), 32'd0);
    step(); chk("t1_valid_T1", 32'(o_valid), 32'd1);
    step(); chk("t1_valid_T2", 32'(o_valid), 32'd1);
    step(); chk("t1_valid_T3", 32'(o_valid), 32'd1);
    step();
    chk("t1_valid_end", 32'(o_valid), 32'd0);
    chk("t1_busy_end", 32'(o_busy), 32'd0);
    chk("t1_remaining", 32'(exp_addr.size()), 32'd0);
    i_left_ready = 1'b0;
    step();

    // Padded right buffer: only entry 0 carries data.
    set_random(1, 0);
    set_entry(1, 0, 10, 11, 12, -4, 9);
    set_entry(1, 1, 20, 21, 22, int'($urandom_range(0, 65535)), 0);
    set_entry(1, 2, 30, 31, 32, int'($urandom_range(0, 65535)), 0);
    push_exp(1);
    n0 = n_xfer;
    i_right_ready = 1'b1;
    step();
    drain(20, 0);
    chk("t2_pair_count", 32'(n_xfer - n0), 32'd1);
    chk("t2_busy", 32'(o_busy), 32'd0);
    i_right_ready = 1'b0;
    step();

    // Backpressure mid-stream.
    for (int e = 0; e < N_ENT; e++) set_entry(0, e, e, e + 1, e + 2, 1, e + 2);
    push_exp(0);
    n0 = n_xfer;
    i_ready = 1'b1; i_left_ready = 1'b1;
    step(); step(); step();
    i_ready = 1'b0;
    step(); step(); step();
    i_ready = 1'b1;
    drain(20, 0);
    chk("t3_pair_count", 32'(n_xfer - n0), 32'd3);
    i_left_ready = 1'b0;
    step();

    // Simultaneous rise: left drains first, six pairs back-to-back.
    set_random(0, 0);
    set_random(1, 0);
    push_exp(0);
    push_exp(1);
    i_left_ready = 1'b1; i_right_ready = 1'b1;
    step();
    for (int c = 0; c < 6; c++) begin
      step();
      chk("t4_back_to_back", 32'(o_valid), 32'd1);
    end
    step();
    chk("t4_valid_end", 32'(o_valid), 32'd0);
    chk("t4_remaining", 32'(exp_addr.size()), 32'd0);
    i_left_ready = 1'b0; i_right_ready = 1'b0;
    step();

    // Overrun: left re-rises while its slot is still full.
    i_ready = 1'b0;
    set_random(0, 0);
    push_exp(0);
    i_left_ready = 1'b1;
    step(); step();
    i_left_ready = 1'b0;
    step();
    chk("t5_no_overrun_yet", 32'(o_overrun), 32'd0);
    set_random(0, 0);
    i_left_ready = 1'b1;
    step();
    chk("t5_overrun", 32'(o_overrun), 32'd1);
    i_left_ready = 1'b0;
    i_ready = 1'b1;
    drain(20, 0);
    chk("t5_overrun_sticky", 32'(o_overrun), 32'd1);
    step();

    // Reset after the first of three pairs.
    set_random(0, 0);
    push_exp(0);
    i_left_ready = 1'b1;
    step(); step(); step();
    i_rst_n = 1'b0;
    #1;
    chk("t6_valid_in_reset", 32'(o_valid), 32'd0);
    chk("t6_busy_in_reset", 32'(o_busy), 32'd0);
    chk("t6_overrun_cleared", 32'(o_overrun), 32'd0);
    exp_addr.delete();
    exp_prod.delete();
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      chk("t6_no_recapture", 32'(o_valid), 32'd0);
    end
    chk("t6_busy_after", 32'(o_busy), 32'd0);
    i_left_ready = 1'b0;
    step();

    // Randomized captures with random backpressure.
    for (int it = 0; it < 30; it++) begin
      int side;
      side = int'($urandom_range(0, 2));
      if (side != 1) set_random(0, 1);
      if (side != 0) set_random(1, 1);
      if (side != 1) push_exp(0);
      if (side != 0) push_exp(1);
      i_left_ready  = (side != 1);
      i_right_ready = (side != 0);
      i_ready = ($urandom_range(0, 1) != 0);
      step();
      i_left_ready = 1'b0; i_right_ready = 1'b0;
      step();
      drain(60, 1);
      step();
      chk("rand_idle", 32'(o_busy), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vp_decoder.md
Name: vp_decoder

Overview:
- Consumer end of the V-P encoder's ping-pong output.
- Captures each completed 3-entry left or right buffer when its ready flag rises. Each entry is an (x,y,k) address, a weight and an activation.
- Multiplies weight by activation per entry and streams (address, product) pairs one per cycle over a valid/ready handshake to the partial-sum accumulator.
- Skips zero-activation padding entries and flags overruns when the encoder refills a side before it has drained.

Parameters:
- ADDR_W, 7, width of each of x, y, k coordinate fields.
- DATA_W, 16, signed width of weight and activation.
- N_ENT, 3, entries per ping-pong buffer.
- PROD_W, 2*DATA_W, signed product width (derived, not overridable).

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_left_ready  in  1  left buffer complete (level from encoder).
- i_right_ready  in  1  right buffer complete (level from encoder).
- i_addr_left_buffer  in  N_ENT x 3 x ADDR_W  left addresses {x,y,k}.
- i_w_data_left_buffer  in  N_ENT x DATA_W signed  left weights.
- i_ia_data_left_buffer  in  N_ENT x DATA_W signed  left activations.
- i_addr_right_buffer, i_w_data_right_buffer, i_ia_data_right_buffer  in  same  right side.
- o_valid  out  1  output pair valid.
- i_ready  in  1  downstream accepts pair.
- o_addr  out  3 x ADDR_W  {x,y,k} of product.
- o_product  out  PROD_W signed  w * ia, full precision.
- o_busy  out  1  any slot full or o_valid high.
- o_overrun  out  1  sticky: capture arrived while the same-side slot was still full.

Behaviour:
- Reset: all slots empty, prev-ready regs 0, o_valid=0, o_addr=0, o_product=0, o_busy=0, o_overrun=0. Reset mid-stream discards all captured data with no output.
- Capture:
  - Rising edge of i_left_ready (prev=0, cur=1 sampled at a posedge) copies all left-buffer inputs into the left slot at that same posedge and marks it full. Right side is identical.
  - A level held high produces no recapture.
- Arrival order: a 1-bit order register records which slot was filled first. If both sides rise on the same posedge, left is ordered first.
- Overrun: rise on a side whose slot is still full → new data dropped, o_overrun set until reset, old slot content unaffected.
- States:
  - IDLE: no slot being drained. When any slot is full, pick the oldest, entry index=0, go to DRAIN.
  - DRAIN: scan entries index..N_ENT-1. Skip entries with ia==0, which costs no cycles: use the first nonzero entry at or after index.
    - When the output register is empty or i_ready=1, register {addr, w*ia} into the outputs, set o_valid=1 and advance index past that entry.
    - When no nonzero entry remains, free the slot the same cycle and pick the other slot if it is full (stay in DRAIN), else go to IDLE.
    - A slot that is all-zero ia is freed in one cycle with no output.
- Latency: ready rise sampled at posedge T0 → o_valid high after posedge T1 (entry 0 nonzero).
- Throughput: 1 pair per cycle while i_ready=1; a full 3-entry slot drains in 3 cycles, back-to-back slots continue without a bubble.
- Handshake:
  - o_valid, o_addr and o_product are held stable until o_valid && i_ready.
  - o_valid drops the cycle after the last transfer if there is nothing further.
  - i_ready is allowed while o_valid=0 (ignored).
- A slot is freed for recapture the same posedge its last entry is issued. A capture on that same posedge into that side is accepted, not an overrun.
- Arithmetic: signed DATA_W x signed DATA_W → PROD_W, no truncation or saturation.
- o_busy = left_full | right_full | o_valid.

Decomposition:
- Shared package vp_pkg:
  - ADDR_W, DATA_W, N_ENT localparams.
  - typedef vp_addr_t (3 x ADDR_W packed {x,y,k}).
  - typedef vp_entry_t {addr, w, ia}.
  - typedef vp_slot_t (N_ENT x vp_entry_t plus full bit).
  - State enum.
- Sub-module vp_slot_capture, instantiated twice (left/right): edge detect, slot storage, full flag, overrun detection.

Test Plan:
- Single left buffer:
  - Stimulus: ia={2,3,4}, w={5,-6,7}, addrs {1,2,3},{4,5,6},{7,8,9}, i_ready=1.
  - Response: products 10,-18,28 on 3 consecutive cycles, first o_valid after T1, then o_busy=0.
- Padded right buffer:
  - Stimulus: ia={9,0,0}, w={-4,x,x}.
  - Response: exactly one pair, product -36, addr of entry 0.
- Backpressure:
  - Stimulus: left buffer {1,1,1}x{2,3,4} with i_ready low for 3 cycles mid-stream.
  - Response: outputs held stable, sequence 2,3,4 with no loss or duplication.
- Simultaneous rise:
  - Stimulus: left and right ready rise on the same posedge.
  - Response: all left pairs before right, 6 pairs back-to-back.
- Overrun:
  - Stimulus: left ready re-rises while the left slot is full under i_ready=0.
  - Response: o_overrun=1 sticky, original left products emitted unchanged.
- Reset mid-drain:
  - Stimulus: assert i_rst_n=0 after 1 of 3 pairs.
  - Response: o_valid=0 immediately, no further pairs; after release a held-high ready yields no recapture.
